// File: rtl/mem_access_ctrl.sv
// ---------------------------------------------------------------------------
// mem_access_ctrl
//
// Purpose:
//   Sits in the MEM stage and turns an EX/MEM load/store into a request on a
//   word-wide data-memory channel. The pipeline is stalled until the request
//   is accepted (stores) or until the read response comes back (loads). The
//   returned word is shifted, masked and sign/zero-extended, then registered
//   into o_load_data. o_load_valid pulses for one cycle when a load completes.
//   Misaligned word/half accesses are flagged and never reach memory.
//
// Ports:
//   i_clk, i_rst        clock (rising edge), asynchronous active-low reset
//   i_valid             EX/MEM slot holds a real instruction
//   i_mem_read/write    load / store (never both set)
//   i_is_word           word access; otherwise i_is_h_or_b: 1 = half, 0 = byte
//   i_is_unsigned_ld    zero-extend a byte/half load instead of sign-extending
//   i_ex_data_out       byte address
//   i_reg_out_2         store data (right-aligned)
//   o_dmem_req/wen      request strobe and write enable
//   o_dmem_addr         word-aligned address
//   o_dmem_mask         byte lanes touched (zero when no request)
//   o_dmem_wdata        store data replicated across lanes
//   i_dmem_ready        memory accepted the request this cycle
//   i_dmem_rvalid/rdata read response (only honoured while waiting for it)
//   o_stall             holds the EX/MEM register
//   o_load_data         last completed load result
//   o_load_valid        one-cycle pulse when o_load_data is updated
//   o_misaligned        valid access with an illegal alignment
// ---------------------------------------------------------------------------
module mem_access_ctrl (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  input  logic        i_mem_read,
  input  logic        i_mem_write,
  input  logic        i_is_word,
  input  logic        i_is_h_or_b,
  input  logic        i_is_unsigned_ld,
  input  logic [31:0] i_ex_data_out,
  input  logic [31:0] i_reg_out_2,
  output logic        o_dmem_req,
  output logic        o_dmem_wen,
  output logic [31:0] o_dmem_addr,
  output logic [3:0]  o_dmem_mask,
  output logic [31:0] o_dmem_wdata,
  input  logic        i_dmem_ready,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_stall,
  output logic [31:0] o_load_data,
  output logic        o_load_valid,
  output logic        o_misaligned
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_t;

  // Access size, captured with the load so extraction does not depend on the
  // EX/MEM inputs still being held when the response arrives.
  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_t;

  state_t      state_q, state_d;
  logic [31:0] load_data_q, load_data_d;
  logic [1:0]  off_q, off_d;
  size_t       size_q, size_d;
  logic        uns_q, uns_d;

  // -------------------------------------------------------------------------
  // Request decode (pure function of the EX/MEM inputs)
  // -------------------------------------------------------------------------
  logic        is_half;
  logic        is_rw;
  logic        bad_align;
  logic        access;
  size_t       size_in;
  logic [3:0]  mask_raw;
  logic [31:0] wdata_raw;
  logic [1:0]  addr_lo;

  assign addr_lo   = i_ex_data_out[1:0];
  assign is_half   = ~i_is_word & i_is_h_or_b;
  assign is_rw     = i_mem_read | i_mem_write;
  assign bad_align = (i_is_word & (addr_lo != 2'b00)) | (is_half & addr_lo[0]);
  assign access    = i_valid & is_rw & ~bad_align;

  assign o_misaligned = i_valid & is_rw & bad_align;

  always_comb begin
    size_in   = SZ_BYTE;
    mask_raw  = 4'b0001 << addr_lo;
    wdata_raw = {4{i_reg_out_2[7:0]}};
    if (i_is_word) begin
      size_in   = SZ_WORD;
      mask_raw  = 4'b1111;
      wdata_raw = i_reg_out_2;
    end else if (i_is_h_or_b) begin
      size_in   = SZ_HALF;
      mask_raw  = addr_lo[1] ? 4'b1100 : 4'b0011;
      wdata_raw = {2{i_reg_out_2[15:0]}};
    end
  end

  // -------------------------------------------------------------------------
  // Load extraction from the response word, using the captured context
  // -------------------------------------------------------------------------
  logic [31:0] rdata_shift;
  logic [31:0] load_ext;

  assign rdata_shift = i_dmem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_ext = i_dmem_rdata;
    case (size_q)
      SZ_BYTE: load_ext = uns_q ? {24'h0, rdata_shift[7:0]}
                                : {{24{rdata_shift[7]}}, rdata_shift[7:0]};
      SZ_HALF: load_ext = uns_q ? {16'h0, rdata_shift[15:0]}
                                : {{16{rdata_shift[15]}}, rdata_shift[15:0]};
      default: load_ext = i_dmem_rdata;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM: next state and outputs
  // -------------------------------------------------------------------------
  logic req_phase;

  always_comb begin
    state_d      = state_q;
    load_data_d  = load_data_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    req_phase    = 1'b0;
    o_dmem_req   = 1'b0;
    o_stall      = 1'b0;
    o_load_valid = 1'b0;

    case (state_q)
      IDLE, REQ: begin
        req_phase  = 1'b1;
        o_dmem_req = access;
        if (access) begin
          if (i_dmem_ready) begin
            if (i_mem_write) begin
              // Accepted store completes now; let the pipeline move on.
              state_d = IDLE;
              o_stall = 1'b0;
            end else begin
              state_d = WAIT;
              o_stall = 1'b1;
              off_d   = addr_lo;
              size_d  = size_in;
              uns_d   = i_is_unsigned_ld;
            end
          end else begin
            state_d = REQ;
            o_stall = 1'b1;
          end
        end else begin
          // Access vanished (only possible if the pipeline dropped it).
          state_d = IDLE;
        end
      end

      WAIT: begin
        o_stall = 1'b1;
        if (i_dmem_rvalid) begin
          load_data_d = load_ext;
          state_d     = DONE;
        end
      end

      DONE: begin
        // Stall released here; the same load is still on the inputs this
        // cycle, so no request may be raised.
        o_load_valid = 1'b1;
        state_d      = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Request fields are only meaningful while a request can be issued.
  assign o_dmem_wen   = req_phase & i_mem_write;
  assign o_dmem_addr  = {i_ex_data_out[31:2], 2'b00};
  assign o_dmem_mask  = o_dmem_req ? mask_raw : 4'b0000;
  assign o_dmem_wdata = wdata_raw;
  assign o_load_data  = load_data_q;

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q     <= IDLE;
      load_data_q <= 32'h0;
      off_q       <= 2'b00;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      load_data_q <= load_data_d;
      off_q       <= off_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_valid, i_mem_read, i_mem_write;
  logic        i_is_word, i_is_h_or_b, i_is_unsigned_ld;
  logic [31:0] i_ex_data_out, i_reg_out_2;
  logic        o_dmem_req, o_dmem_wen;
  logic [31:0] o_dmem_addr;
  logic [3:0]  o_dmem_mask;
  logic [31:0] o_dmem_wdata;
  logic        i_dmem_ready, i_dmem_rvalid;
  logic [31:0] i_dmem_rdata;
  logic        o_stall;
  logic [31:0] o_load_data;
  logic        o_load_valid, o_misaligned;

  int n_vec = 0;
  int n_err = 0;

  always #5 i_clk = ~i_clk;

  mem_access_ctrl dut (
    .i_clk            (i_clk),
    .i_rst            (i_rst),
    .i_valid          (i_valid),
    .i_mem_read       (i_mem_read),
    .i_mem_write      (i_mem_write),
    .i_is_word        (i_is_word),
    .i_is_h_or_b      (i_is_h_or_b),
    .i_is_unsigned_ld (i_is_unsigned_ld),
    .i_ex_data_out    (i_ex_data_out),
    .i_reg_out_2      (i_reg_out_2),
    .o_dmem_req       (o_dmem_req),
    .o_dmem_wen       (o_dmem_wen),
    .o_dmem_addr      (o_dmem_addr),
    .o_dmem_mask      (o_dmem_mask),
    .o_dmem_wdata     (o_dmem_wdata),
    .i_dmem_ready     (i_dmem_ready),
    .i_dmem_rvalid    (i_dmem_rvalid),
    .i_dmem_rdata     (i_dmem_rdata),
    .o_stall          (o_stall),
    .o_load_data      (o_load_data),
    .o_load_valid     (o_load_valid),
    .o_misaligned     (o_misaligned)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are read on the
  // falling edge of the same cycle.
  task automatic next_cycle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge i_clk);
  endtask

  task automatic idle_inputs();
    i_valid = 1'b0; i_mem_read = 1'b0; i_mem_write = 1'b0;
    i_is_word = 1'b0; i_is_h_or_b = 1'b0; i_is_unsigned_ld = 1'b0;
    i_ex_data_out = 32'h0; i_reg_out_2 = 32'h0;
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
  endtask

  // Minimum-latency load: accepted at once, response one cycle later.
  task automatic do_load(input string tag, input logic [31:0] addr, input logic word,
                         input logic hb, input logic uns, input logic [31:0] rdata,
                         input logic [31:0] exp);
    next_cycle();
    i_valid = 1'b1; i_mem_read = 1'b1; i_mem_write = 1'b0;
    i_is_word = word; i_is_h_or_b = hb; i_is_unsigned_ld = uns;
    i_ex_data_out = addr; i_dmem_ready = 1'b1;
    sample();
    chk({tag, "_req"}, o_dmem_req, 1);
    chk({tag, "_stall_acc"}, o_stall, 1);
    next_cycle();
    i_dmem_ready = 1'b0; i_dmem_rvalid = 1'b1; i_dmem_rdata = rdata;
    sample();
    chk({tag, "_stall_wait"}, o_stall, 1);
    next_cycle();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    sample();
    chk({tag, "_valid"}, o_load_valid, 1);
    chk({tag, "_data"}, o_load_data, exp);
    chk({tag, "_done_noreq"}, o_dmem_req, 0);
    next_cycle();
    idle_inputs();
    sample();
    chk({tag, "_valid_drop"}, o_load_valid, 0);
    $display("load %s addr=0x%08h rdata=0x%08h -> 0x%08h", tag, addr, rdata, o_load_data);
  endtask

  initial begin
    idle_inputs();
    i_rst = 1'b0;

    // Reset state
    #1;
    chk("rst_stall", o_stall, 0);
    chk("rst_valid", o_load_valid, 0);
    chk("rst_data", o_load_data, 32'h0);
    chk("rst_req", o_dmem_req, 0);
    next_cycle();
    next_cycle();
    i_rst = 1'b1;

    // sb addr=0x103 data=0xAB, accepted immediately
    next_cycle();
    i_valid = 1'b1; i_mem_write = 1'b1; i_ex_data_out = 32'h103;
    i_reg_out_2 = 32'h0000_00AB; i_dmem_ready = 1'b1;
    sample();
    chk("sb_req", o_dmem_req, 1);
    chk("sb_wen", o_dmem_wen, 1);
    chk("sb_mask", o_dmem_mask, 4'b1000);
    chk("sb_wdata", o_dmem_wdata, 32'hABAB_ABAB);
    chk("sb_addr", o_dmem_addr, 32'h100);
    chk("sb_stall", o_stall, 0);
    $display("sb addr=0x103 mask=%b wdata=0x%08h", o_dmem_mask, o_dmem_wdata);
    next_cycle();
    idle_inputs();
    sample();
    chk("sb_after_req", o_dmem_req, 0);
    chk("sb_after_stall", o_stall, 0);
    chk("sb_after_mask", o_dmem_mask, 4'b0000);

    // lh addr=0x202 signed, response two cycles after acceptance
    next_cycle();
    i_valid = 1'b1; i_mem_read = 1'b1; i_is_h_or_b = 1'b1;
    i_ex_data_out = 32'h202; i_dmem_ready = 1'b1;
    sample();
    chk("lh_req", o_dmem_req, 1);
    chk("lh_wen", o_dmem_wen, 0);
    chk("lh_mask", o_dmem_mask, 4'b1100);
    chk("lh_stall1", o_stall, 1);
    next_cycle();
    i_dmem_ready = 1'b0;
    sample();
    chk("lh_stall2", o_stall, 1);
    chk("lh_wait_noreq", o_dmem_req, 0);
    next_cycle();
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h8001_1234;
    sample();
    chk("lh_stall3", o_stall, 1);
    chk("lh_not_yet_valid", o_load_valid, 0);
    next_cycle();
    i_dmem_rvalid = 1'b0; i_dmem_rdata = 32'h0;
    sample();
    chk("lh_done_stall", o_stall, 0);
    chk("lh_done_valid", o_load_valid, 1);
    chk("lh_done_data", o_load_data, 32'hFFFF_8001);
    chk("lh_done_noreq", o_dmem_req, 0);
    $display("lh addr=0x202 -> 0x%08h", o_load_data);
    next_cycle();
    idle_inputs();
    sample();
    chk("lh_valid_drop", o_load_valid, 0);
    chk("lh_data_hold", o_load_data, 32'hFFFF_8001);

    // Byte / half / word extraction variants
    do_load("lbu", 32'h1, 1'b0, 1'b0, 1'b1, 32'h0000_F000, 32'h0000_00F0);
    do_load("lb",  32'h1, 1'b0, 1'b0, 1'b0, 32'h0000_F000, 32'hFFFF_FFF0);
    do_load("lhu", 32'h2, 1'b0, 1'b1, 1'b1, 32'h9ABC_1234, 32'h0000_9ABC);
    do_load("lb3", 32'h7, 1'b0, 1'b0, 1'b0, 32'h7F00_0000, 32'h0000_007F);
    do_load("lw",  32'h4, 1'b1, 1'b0, 1'b0, 32'hCAFE_F00D, 32'hCAFE_F00D);

    // rvalid while idle must not produce a load
    next_cycle();
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h1111_1111;
    sample();
    next_cycle();
    i_dmem_rvalid = 1'b0;
    sample();
    chk("idle_rvalid_valid", o_load_valid, 0);
    chk("idle_rvalid_data", o_load_data, 32'hCAFE_F00D);

    // sw with ready held low for 3 cycles, accepted on the 4th
    next_cycle();
    i_valid = 1'b1; i_mem_write = 1'b1; i_is_word = 1'b1;
    i_ex_data_out = 32'h10; i_reg_out_2 = 32'hDEAD_BEEF; i_dmem_ready = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      sample();
      chk($sformatf("sw_hold_req%0d", c), o_dmem_req, 1);
      chk($sformatf("sw_hold_stall%0d", c), o_stall, 1);
      next_cycle();
    end
    i_dmem_ready = 1'b1;
    sample();
    chk("sw_acc_req", o_dmem_req, 1);
    chk("sw_acc_stall", o_stall, 0);
    chk("sw_acc_wdata", o_dmem_wdata, 32'hDEAD_BEEF);
    chk("sw_acc_mask", o_dmem_mask, 4'b1111);
    $display("sw addr=0x10 accepted after 3 wait cycles");
    next_cycle();
    idle_inputs();
    sample();
    chk("sw_idle_stall", o_stall, 0);
    chk("sw_idle_req", o_dmem_req, 0);

    // Misaligned word and half, and an invalid slot
    next_cycle();
    i_valid = 1'b1; i_mem_read = 1'b1; i_is_word = 1'b1; i_ex_data_out = 32'h6;
    i_dmem_ready = 1'b1;
    sample();
    chk("lw_mis_flag", o_misaligned, 1);
    chk("lw_mis_req", o_dmem_req, 0);
    chk("lw_mis_stall", o_stall, 0);
    next_cycle();
    i_is_word = 1'b0; i_is_h_or_b = 1'b1; i_ex_data_out = 32'h3;
    sample();
    chk("lh_mis_flag", o_misaligned, 1);
    chk("lh_mis_req", o_dmem_req, 0);
    next_cycle();
    i_valid = 1'b0; i_is_h_or_b = 1'b0; i_is_word = 1'b1; i_ex_data_out = 32'h6;
    sample();
    chk("inv_mis_flag", o_misaligned, 0);
    chk("inv_req", o_dmem_req, 0);
    chk("inv_stall", o_stall, 0);
    next_cycle();
    idle_inputs();

    // Reset asserted while waiting for a load response
    next_cycle();
    i_valid = 1'b1; i_mem_read = 1'b1; i_is_word = 1'b1; i_ex_data_out = 32'h20;
    i_dmem_ready = 1'b1;
    next_cycle();
    i_dmem_ready = 1'b0;
    sample();
    chk("rstw_stall_before", o_stall, 1);
    i_valid = 1'b0; i_mem_read = 1'b0;
    #1;
    i_rst = 1'b0;
    #1;
    chk("rstw_stall", o_stall, 0);
    chk("rstw_valid", o_load_valid, 0);
    chk("rstw_data", o_load_data, 32'h0);
    next_cycle();
    i_rst = 1'b1;
    i_dmem_rvalid = 1'b1; i_dmem_rdata = 32'h5555_5555;
    sample();
    chk("rstw_late_stall", o_stall, 0);
    next_cycle();
    i_dmem_rvalid = 1'b0;
    sample();
    chk("rstw_late_valid", o_load_valid, 0);
    chk("rstw_late_data", o_load_data, 32'h0);
    $display("reset during WAIT: late response ignored");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed (32-bit data/address, 4-bit byte mask).
REQ-002 SHALL have port i_clk, input, 1: single clock; all state updates on the rising edge.
REQ-003 SHALL have port i_rst, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have inputs i_valid, i_mem_read, i_mem_write, i_is_word, i_is_h_or_b, i_is_unsigned_ld, each 1 bit: EX/MEM register outputs.
- Size encoding: i_is_word=1 is word; otherwise i_is_h_or_b=1 is half, 0 is byte.
REQ-005 SHALL have inputs i_ex_data_out (32) as byte address and i_reg_out_2 (32) as store data.
REQ-006 SHALL have outputs o_dmem_req (1), o_dmem_wen (1), o_dmem_addr (32, word-aligned, bits[1:0]=0), o_dmem_mask (4), o_dmem_wdata (32): data-memory request channel.
REQ-007 SHALL have inputs i_dmem_ready (1, request accepted) and i_dmem_rvalid (1), i_dmem_rdata (32): read-response channel.
REQ-008 SHALL have outputs o_stall (1, drives the EX/MEM stall_thru), o_load_data (32), o_load_valid (1), o_misaligned (1).

Function
REQ-009 SHALL define the access condition as i_valid & (i_mem_read | i_mem_write) & ~misaligned; i_mem_read and i_mem_write are never both 1.
REQ-010 SHALL define misaligned as one of: word with addr[1:0]!=0; half with addr[0]!=0.
- o_misaligned is combinational = i_valid & (rd|wr) & misaligned.
- A misaligned access issues no request and asserts no stall.
REQ-011 SHALL implement states IDLE, REQ, WAIT, DONE.
REQ-012 SHALL drive the request fields combinationally in IDLE and REQ: o_dmem_req = access condition, o_dmem_wen = i_mem_write, o_dmem_addr = {addr[31:2],2'b00}.
REQ-013 SHALL set o_dmem_mask: word 4'b1111; half addr[1] ? 4'b1100 : 4'b0011; byte 4'b0001<<addr[1:0].
- o_dmem_mask is 0 whenever o_dmem_req=0.
REQ-014 SHALL set o_dmem_wdata: word = data; half = {2{data[15:0]}}; byte = {4{data[7:0]}}.
REQ-015 SHALL transition from IDLE on an access:
- store with ready -> IDLE, o_stall=0;
- store without ready -> REQ, o_stall=1;
- load with ready -> WAIT, o_stall=1;
- load without ready -> REQ, o_stall=1.
REQ-016 SHALL transition from REQ (request held):
- store with ready -> IDLE, o_stall=0;
- load with ready -> WAIT, o_stall=1;
- otherwise remain, o_stall=1.
REQ-017 SHALL hold o_stall=1 and o_dmem_req=0 in WAIT.
- On i_dmem_rvalid: register the extracted load into o_load_data and go to DONE.
- i_dmem_rvalid outside WAIT SHALL be ignored.
REQ-018 SHALL extract the load as s = i_dmem_rdata >> (8*addr[1:0]).
- byte: low 8 bits of s; half: low 16 bits of s.
- Sign-extend unless i_is_unsigned_ld=1, in which case zero-extend; word passes through unchanged.
REQ-019 SHALL, in DONE, drive o_load_valid=1, o_stall=0, o_dmem_req=0, and go to IDLE unconditionally.
- DONE SHALL NOT re-issue the load still present on the inputs.
REQ-020 SHALL hold o_load_data stable until the next load completes; o_load_valid is 1 only in DONE.
REQ-021 SHALL NOT allow i_dmem_rvalid in the same cycle as the accepting i_dmem_ready; the memory responds at least one cycle later.
REQ-022 SHALL give a load latency of: acceptance cycle + response cycles + 1 DONE cycle; the minimum is 3 cycles with o_stall high for 2 of them.
REQ-023 SHALL keep o_stall=0 in IDLE when there is no access.

Reset
REQ-024 SHALL, while i_rst=0 (asynchronous), force state IDLE, o_load_data=0, and o_load_valid=0.
- All combinational outputs then evaluate as in IDLE.
REQ-025 SHALL, on reset mid-operation (REQ or WAIT), abandon the access.
- A late i_dmem_rvalid after reset release SHALL be ignored.
- Any pending access is re-evaluated in IDLE on the first cycle after release.

Verification
REQ-026 SHALL cover: sb addr=0x103, data=0x000000AB, ready=1 -> mask=4'b1000, wdata=0xABABABAB, addr=0x100, o_stall=0, state stays IDLE.
REQ-027 SHALL cover: lh addr=0x202 signed, ready=1, rvalid 2 cycles later with rdata=0x8001_1234 -> o_stall high for 3 cycles, then DONE with o_load_data=0xFFFF8001 and o_load_valid=1 for 1 cycle.
REQ-028 SHALL cover: lbu addr=0x1, rdata=0x0000_F000 -> o_load_data=0x000000F0; same access as lb -> 0xFFFFFFF0.
REQ-029 SHALL cover: sw with ready=0 for 3 cycles -> o_dmem_req and o_stall held for 3 cycles; ready on cycle 4 -> o_stall=0 that cycle, state IDLE.
REQ-030 SHALL cover: lw addr=0x6 -> o_misaligned=1, o_dmem_req=0, o_stall=0; i_valid=0 with i_mem_read=1 -> no request and o_misaligned=0.
REQ-031 SHALL cover: i_rst pulsed low while in WAIT -> o_stall=0 and o_load_valid=0 immediately; a subsequent rvalid does not assert o_load_valid.
